// File: rtl/jtkunio_scr_romslot.sv
// Scroll ROM slot: turns a 32-bit-aligned halfword address into a two-beat SDRAM
// burst and keeps the assembled word in a one-entry tag cache.
module jtkunio_scr_romslot #(
    parameter int          AW     = 17,
    parameter logic [21:0] OFFSET = 22'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          slot_cs,
    input  logic [AW-1:0] slot_addr,
    output logic [31:0]   slot_dout,
    output logic          slot_ok,
    output logic          sdram_req,
    output logic [21:0]   sdram_addr,
    input  logic          sdram_ack,
    input  logic          sdram_dst,
    input  logic [15:0]   sdram_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BEAT0 = 2'd2,
        BEAT1 = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          valid_q, valid_d;
    logic [AW-1:0] tag_q, tag_d;
    logic [AW-1:0] req_addr_q, req_addr_d;
    logic [15:0]   lo_q, lo_d;
    logic [31:0]   dout_q, dout_d;
    logic          req_q, req_d;
    logic [21:0]   addr_q, addr_d;
    logic          hit;
    logic          miss;

    assign hit        = valid_q && (tag_q == slot_addr);
    assign miss       = slot_cs && !hit;
    assign slot_ok    = slot_cs && hit;
    assign slot_dout  = dout_q;
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        req_addr_d = req_addr_q;
        lo_d       = lo_q;
        dout_d     = dout_q;
        req_d      = req_q;
        addr_d     = addr_q;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    // The cached word is dropped as soon as a new fetch starts
                    req_addr_d = slot_addr;
                    addr_d     = OFFSET + 22'(slot_addr);
                    req_d      = 1'b1;
                    valid_d    = 1'b0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (sdram_ack) begin
                    req_d   = 1'b0;
                    state_d = BEAT0;
                end
            end
            BEAT0: begin
                if (sdram_dst) begin
                    lo_d    = sdram_data;
                    state_d = BEAT1;
                end
            end
            BEAT1: begin
                // Whole word lands at once, tagged with the address that was fetched
                if (sdram_dst) begin
                    dout_d  = {sdram_data, lo_q};
                    tag_d   = req_addr_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            tag_q      <= '0;
            req_addr_q <= '0;
            lo_q       <= '0;
            dout_q     <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            req_addr_q <= req_addr_d;
            lo_q       <= lo_d;
            dout_q     <= dout_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
        end
    end

endmodule

// File: tb/tb_jtkunio_scr_romslot.sv
// Scoreboard bench for jtkunio_scr_romslot: expected SDRAM addresses and words are
// queued when stimulus is driven and compared when the DUT presents them.
module tb_jtkunio_scr_romslot;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          slot_cs;
    logic [AW-1:0] slot_addr;
    logic [31:0]   slot_dout;
    logic          slot_ok;
    logic          sdram_req;
    logic [21:0]   sdram_addr;
    logic          sdram_ack;
    logic          sdram_dst;
    logic [15:0]   sdram_data;

    logic          w_cs;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_dout;
    logic          w_ok;
    logic          w_req;
    logic [21:0]   w_sdram_addr;

    int errors = 0;
    int checks = 0;

    logic [21:0] exp_addr_q[$];
    logic [31:0] exp_word_q[$];

    always #5 clk = ~clk;

    jtkunio_scr_romslot #(.AW(AW), .OFFSET(22'h080000)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .slot_cs    (slot_cs),
        .slot_addr  (slot_addr),
        .slot_dout  (slot_dout),
        .slot_ok    (slot_ok),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_dst  (sdram_dst),
        .sdram_data (sdram_data)
    );

    jtkunio_scr_romslot #(.AW(AW), .OFFSET(22'h3FFFF0)) u_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .slot_cs    (w_cs),
        .slot_addr  (w_addr),
        .slot_dout  (w_dout),
        .slot_ok    (w_ok),
        .sdram_req  (w_req),
        .sdram_addr (w_sdram_addr),
        .sdram_ack  (1'b0),
        .sdram_dst  (1'b0),
        .sdram_data (16'h0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Waits for a request, checks it against the queue, optionally delays the ack,
    // optionally retargets the slot address right after the ack, then drives both beats.
    task automatic fill(input logic [15:0] lo, input logic [15:0] hi, input int ack_dly,
                        input bit chg, input logic [AW-1:0] new_addr, input logic [21:0] new_exp);
        int          n;
        int          bad;
        logic [21:0] a0;
        n = 0;
        while (!sdram_req && n < 64) begin
            tick();
            n++;
        end
        chk("req_seen", 32'(sdram_req), 32'd1);
        if (exp_addr_q.size() > 0) chk("req_addr", 32'(sdram_addr), 32'(exp_addr_q.pop_front()));
        else chk("req_addr_queue", 32'(exp_addr_q.size()), 32'd1);
        a0  = sdram_addr;
        bad = 0;
        for (int i = 0; i < ack_dly; i++) begin
            if (!sdram_req || sdram_addr !== a0 || slot_ok) bad++;
            sdram_dst  = (i == 5);
            sdram_data = 16'hdead;
            tick();
            sdram_dst  = 1'b0;
        end
        chk("req_stable", 32'(bad), 32'd0);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        chk("req_drop", 32'(sdram_req), 32'd0);
        if (chg) begin
            slot_addr = new_addr;
            exp_addr_q.push_back(new_exp);
        end
        exp_word_q.push_back({hi, lo});
        sdram_dst  = 1'b1;
        sdram_data = lo;
        tick();
        chk("ok_mid_burst", 32'(slot_ok), 32'd0);
        sdram_data = hi;
        tick();
        sdram_dst  = 1'b0;
    endtask

    task automatic check_word(input string tag, input bit exp_ok);
        if (exp_word_q.size() > 0) chk({tag, "_dout"}, slot_dout, exp_word_q.pop_front());
        else chk({tag, "_word_queue"}, 32'(exp_word_q.size()), 32'd1);
        chk({tag, "_ok"}, 32'(slot_ok), 32'(exp_ok));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int req_cnt;
        int ok_cnt;
        rst_n      = 1'b0;
        slot_cs    = 1'b1;
        slot_addr  = '0;
        sdram_ack  = 1'b0;
        sdram_dst  = 1'b0;
        sdram_data = '0;
        w_cs       = 1'b0;
        w_addr     = '0;
        tick();
        tick();
        chk("rst_dout", slot_dout, 32'h0);
        chk("rst_ok", 32'(slot_ok), 32'd0);
        chk("rst_req", 32'(sdram_req), 32'd0);
        chk("rst_addr", 32'(sdram_addr), 32'd0);
        slot_cs = 1'b0;
        rst_n   = 1'b1;
        tick();
        chk("idle_no_cs_req", 32'(sdram_req), 32'd0);

        // Basic fill
        slot_cs   = 1'b1;
        slot_addr = 17'h00100;
        exp_addr_q.push_back(22'h080100);
        fill(16'h3322, 16'h7766, 0, 1'b0, '0, '0);
        check_word("fill1", 1'b1);

        // Hit: no traffic while the address is held
        req_cnt = 0;
        ok_cnt  = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (sdram_req) req_cnt++;
            if (slot_ok) ok_cnt++;
        end
        chk("hold_req_cnt", 32'(req_cnt), 32'd0);
        chk("hold_ok_cnt", 32'(ok_cnt), 32'd50);
        slot_cs = 1'b0;
        #1;
        chk("cs_low_ok", 32'(slot_ok), 32'd0);
        tick();
        chk("cs_low_req", 32'(sdram_req), 32'd0);
        slot_cs = 1'b1;

        // Address change between ack and first beat
        slot_addr = 17'h00200;
        exp_addr_q.push_back(22'h080200);
        fill(16'haaaa, 16'hbbbb, 0, 1'b1, 17'h00202, 22'h080202);
        check_word("stale", 1'b0);
        fill(16'hcccc, 16'hdddd, 0, 1'b0, '0, '0);
        check_word("refill", 1'b1);

        // Late ack, with a stray strobe while still requesting
        slot_addr = 17'h00300;
        exp_addr_q.push_back(22'h080300);
        fill(16'h5555, 16'h6666, 20, 1'b0, '0, '0);
        check_word("late_ack", 1'b1);

        // Reset in BEAT1, then a late strobe in IDLE
        slot_addr = 17'h00400;
        exp_addr_q.push_back(22'h080400);
        begin
            int n = 0;
            while (!sdram_req && n < 64) begin
                tick();
                n++;
            end
        end
        chk("rst_case_req", 32'(sdram_req), 32'd1);
        chk("rst_case_addr", 32'(sdram_addr), 32'(exp_addr_q.pop_front()));
        sdram_ack = 1'b1;
        tick();
        sdram_ack  = 1'b0;
        sdram_dst  = 1'b1;
        sdram_data = 16'h1234;
        tick();
        sdram_dst = 1'b0;
        rst_n     = 1'b0;
        tick();
        chk("midrst_dout", slot_dout, 32'h0);
        chk("midrst_ok", 32'(slot_ok), 32'd0);
        chk("midrst_req", 32'(sdram_req), 32'd0);
        slot_cs = 1'b0;
        rst_n   = 1'b1;
        tick();
        sdram_dst  = 1'b1;
        sdram_data = 16'hffff;
        tick();
        sdram_dst = 1'b0;
        tick();
        chk("late_dst_dout", slot_dout, 32'h0);
        slot_cs   = 1'b1;
        slot_addr = 17'h00000;
        #1;
        chk("late_dst_ok", 32'(slot_ok), 32'd0);
        slot_addr = 17'h00400;
        exp_addr_q.push_back(22'h080400);
        fill(16'h1111, 16'h2222, 0, 1'b0, '0, '0);
        check_word("post_rst", 1'b1);

        // Address wrap on the second instance
        w_cs   = 1'b1;
        w_addr = 17'h00020;
        exp_addr_q.push_back(22'h000010);
        tick();
        chk("wrap_req", 32'(w_req), 32'd1);
        chk("wrap_addr", 32'(w_sdram_addr), 32'(exp_addr_q.pop_front()));
        chk("wrap_ok", 32'(w_ok), 32'd0);
        chk("wrap_dout", w_dout, 32'h0);
        chk("queues_empty", 32'(exp_addr_q.size() + exp_word_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
